// File: rtl/fp_div_seq.sv
// FP64 divider sequencer: handshake in, special-case resolve, 55-step restoring mantissa loop, normalize/round/pack, hold result.
// Latency: special operands 1 cycle after acceptance, normal operands 57 cycles; FP_DIV_RNE_EN selects round-nearest-even, else truncation.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    state_t             state;
    logic [63:0]        a_q;
    logic [63:0]        b_q;
    logic               sign;
    logic [52:0]        mb;
    logic [53:0]        rem;
    logic [54:0]        quo;
    logic signed [12:0] exp_q;
    logic [5:0]         iter;

    logic [10:0] a_exp, b_exp;
    logic [51:0] a_frac, b_frac;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_exp  = a_q[62:52];
    assign b_exp  = b_q[62:52];
    assign a_frac = a_q[51:0];
    assign b_frac = b_q[51:0];
    // Subnormals are treated as zero, so only the exponent decides zero-ness.
    assign a_zero = (a_exp == 11'd0);
    assign b_zero = (b_exp == 11'd0);
    assign a_inf  = (a_exp == 11'h7FF) && (a_frac == 52'd0);
    assign b_inf  = (b_exp == 11'h7FF) && (b_frac == 52'd0);
    assign a_nan  = (a_exp == 11'h7FF) && (a_frac != 52'd0);
    assign b_nan  = (b_exp == 11'h7FF) && (b_frac != 52'd0);

    logic        rem_ge;
    logic [53:0] rem_sub;
    logic [53:0] rem_nxt;

    assign rem_ge  = (rem >= {1'b0, mb});
    assign rem_sub = rem_ge ? (rem - {1'b0, mb}) : rem;
    assign rem_nxt = rem_sub << 1;

    logic [51:0]        n_mant;
    logic signed [12:0] n_exp;
    logic [63:0]        norm_res;
`ifdef FP_DIV_RNE_EN
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [52:0] mant_rnd;
`endif

    always_comb begin
        n_mant = 52'd0;
        n_exp  = exp_q;
        if (quo[54]) begin
            n_mant = quo[53:2];
        end else begin
            n_mant = quo[52:1];
            n_exp  = exp_q - 13'sd1;
        end
`ifdef FP_DIV_RNE_EN
        guard    = quo[54] ? quo[1] : quo[0];
        sticky   = (quo[54] & quo[0]) | (|rem);
        round_up = guard & (sticky | n_mant[0]);
        mant_rnd = {1'b0, n_mant} + {52'd0, round_up};
        n_mant   = mant_rnd[51:0];
        if (mant_rnd[52]) begin
            n_exp = n_exp + 13'sd1;
        end
`endif
        if (n_exp <= 13'sd0) begin
            norm_res = {sign, 63'd0};
        end else if (n_exp >= 13'sd2047) begin
            norm_res = {sign, 11'h7FF, 52'd0};
        end else begin
            norm_res = {sign, n_exp[10:0], n_mant};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= 64'd0;
            a_q       <= 64'd0;
            b_q       <= 64'd0;
            sign      <= 1'b0;
            mb        <= 53'd0;
            rem       <= 54'd0;
            quo       <= 55'd0;
            exp_q     <= 13'sd0;
            iter      <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        state    <= S_SETUP;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    sign <= a_q[63] ^ b_q[63];
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result    <= QNAN;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else if (b_zero || a_inf) begin
                        result    <= {a_q[63] ^ b_q[63], 11'h7FF, 52'd0};
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else if (a_zero || b_inf) begin
                        result    <= {a_q[63] ^ b_q[63], 63'd0};
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        mb    <= {1'b1, b_frac};
                        rem   <= {2'b01, a_frac};
                        quo   <= 55'd0;
                        exp_q <= 13'({2'b00, a_exp}) - 13'({2'b00, b_exp}) + 13'sd1023;
                        iter  <= 6'd0;
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    quo  <= {quo[53:0], rem_ge};
                    rem  <= rem_nxt;
                    iter <= iter + 6'd1;
                    if (iter == 6'd54) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    result    <= norm_res;
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
